data_sram_resp: RTL and testbench



---
 rtl/data_sram_resp.sv | 152 +++++++++++++++
 tb/tb_data_sram_resp.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_resp.sv
// data_sram_resp: single-outstanding 64-bit SRAM responder with fixed
// accept-to-response latency. It performs byte-lane stores and right-justified
// loads, and flags out-of-range addresses.
// Optional build macro DATA_SRAM_MISALIGN_CHK_EN: a store that would drop a
// lane past byte 7 returns resp_err=1 and writes nothing.
//
// Handshakes use strict valid/ready semantics. A transfer happens on a rising
// edge where valid & ready are both 1. The valid signal is never withdrawn
// before that transfer, and the payload stays stable while valid is high.
module data_sram_resp #(
    parameter int          LATENCY    = 2,
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // LATENCY==1 skips BUSY entirely; otherwise BUSY lasts LATENCY-1 cycles.
    localparam logic       DIRECT   = (LATENCY == 1);
    localparam logic [2:0] CNT_INIT = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

    logic [1:0]  state;
    logic [2:0]  cnt;
    logic [63:0] lat_addr;
    logic        lat_wen;
    logic [63:0] lat_wdata;
    logic [7:0]  lat_wmask;

    logic [63:0] mem [0:(2**DEPTH_LOG2)-1];

    logic        accept;
    logic        enter_resp;
    logic [63:0] acc_addr;
    logic        acc_wen;
    logic [63:0] acc_wdata;
    logic [7:0]  acc_wmask;
    logic [60:0] word_num;
    logic [DEPTH_LOG2-1:0] idx;
    logic [2:0]  acc_off;
    logic [15:0] mask_wide;
    logic [63:0] data_sh;
    logic        out_of_range;
    logic        misalign_err;
    logic        access_err;
    logic        do_write;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid & req_ready;

    // Operands of the access. In IDLE they come straight from the request,
    // which only matters for LATENCY==1. Otherwise they come from the latched copy.
    assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign acc_wen   = (state == IDLE) ? req_wen   : lat_wen;
    assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign acc_wmask = (state == IDLE) ? req_wmask : lat_wmask;

    assign enter_resp = ((state == IDLE) & accept & DIRECT) |
                        ((state == BUSY) & (cnt == 3'd0));

    assign word_num     = 61'((acc_addr - BASE_ADDR) >> 3);
    assign idx          = word_num[DEPTH_LOG2-1:0];
    assign acc_off      = acc_addr[2:0];
    assign out_of_range = (acc_addr < BASE_ADDR) | (|word_num[60:DEPTH_LOG2]);

    // Lanes shifted past byte 7 land in mask_wide[15:8] and are dropped.
    assign mask_wide = {8'b0, acc_wmask} << acc_off;
    assign data_sh   = acc_wdata << {acc_off, 3'b000};

`ifdef DATA_SRAM_MISALIGN_CHK_EN
    assign misalign_err = acc_wen & (|mask_wide[15:8]);
`else
    assign misalign_err = 1'b0;
`endif

    assign access_err = out_of_range | misalign_err;
    assign do_write   = enter_resp & acc_wen & ~access_err & ~rst;

    // Request capture: payload frozen at the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_wen   <= 1'b0;
            lat_wdata <= '0;
            lat_wmask <= '0;
        end else if (accept) begin
            lat_addr  <= req_addr;
            lat_wen   <= req_wen;
            lat_wdata <= req_wdata;
            lat_wmask <= req_wmask;
        end
    end

    // Control FSM plus the response registers, which are loaded on entry to RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (DIRECT) begin
                            state <= RESP;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 3'd0) state <= RESP;
                    else             cnt   <= cnt - 3'd1;
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                resp_err <= access_err;
                if (acc_wen | access_err) resp_rdata <= '0;
                else                      resp_rdata <= mem[idx] >> {acc_off, 3'b000};
            end
        end
    end

    // Single write port with byte enables. The array itself is never reset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < 8; j++) begin
            if (do_write && mask_wide[j]) mem[idx][8*j +: 8] <= data_sh[8*j +: 8];
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Testbench for data_sram_resp. It covers directed vectors, handshake hold,
// reset abort, and randomized traffic against a byte-level reference model.
module tb_data_sram_resp;

    localparam int          LAT  = 2;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] SPAN = 64'd32768; // 4096 words * 8 bytes

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic        req_wen = 1'b0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int errors = 0;
    int checks = 0;

    logic [64:0] exp_q[$];
    logic [63:0] ref_mem [0:7];

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t tbl [15];

    data_sram_resp #(.LATENCY(LAT), .DEPTH_LOG2(12), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    // Clock generation
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: byte-by-byte view of words BASE..BASE+63
    function automatic void model_op(input logic [63:0] addr, input logic wen,
                                     input logic [63:0] wdata, input logic [7:0] wmask,
                                     output logic err, output logic [63:0] rdata);
        int k;
        int o;
        err = 1'b0;
        rdata = '0;
        if (addr < BASE || addr >= BASE + SPAN) begin
            err = 1'b1;
            return;
        end
        k = int'((addr - BASE) / 64'd8);
        o = int'(addr % 64'd8);
        if (wen) begin
`ifdef DATA_SRAM_MISALIGN_CHK_EN
            for (int i = 0; i < 8; i++)
                if (wmask[i] && i + o > 7) err = 1'b1;
            if (err) return;
`endif
            for (int i = 0; i < 8; i++)
                if (wmask[i] && i + o < 8) ref_mem[k][8*(i+o) +: 8] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < 8; i++)
                if (i + o < 8) rdata[8*i +: 8] = ref_mem[k][8*(i+o) +: 8];
        end
    endfunction

    // Driver: starts and ends at a negedge; checks latency and hold stability
    task automatic do_req(input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
                          input logic [7:0] wmask, output logic [63:0] rdata, output logic err);
        int n;
        int lat;
        int hold;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("req_ready_timeout", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wen   = wen;
        req_wdata = wdata;
        req_wmask = wmask;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        req_wen   = 1'($urandom);
        req_wdata = {$urandom, $urandom};
        req_wmask = 8'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        check("latency", 64'(lat), 64'(LAT));
        rdata = resp_rdata;
        err   = resp_err;
        hold  = $urandom_range(0, 2);
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_rdata", resp_rdata, rdata);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        logic [63:0] held;
        logic [64:0] exp;
        int          n;

        tbl[0]  = '{BASE,              1'b1, 64'h1122334455667788, 8'hFF, 1'b0, 64'h0};
        tbl[1]  = '{BASE,              1'b0, 64'h0,                8'h00, 1'b0, 64'h1122334455667788};
        tbl[2]  = '{BASE + 64'd3,      1'b1, 64'hAABB,             8'h03, 1'b0, 64'h0};
        tbl[3]  = '{BASE,              1'b0, 64'h0,                8'h00, 1'b0, 64'h112233AABB667788};
        tbl[4]  = '{BASE + 64'd3,      1'b0, 64'h0,                8'h00, 1'b0, 64'h000000112233AABB};
        tbl[5]  = '{64'h7FFF_FFF8,     1'b0, 64'h0,                8'h00, 1'b1, 64'h0};
        tbl[6]  = '{64'h8000_8000,     1'b0, 64'h0,                8'h00, 1'b1, 64'h0};
        tbl[7]  = '{64'h8000_8000,     1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 64'h0};
        tbl[8]  = '{BASE,              1'b0, 64'h0,                8'h00, 1'b0, 64'h112233AABB667788};
        tbl[9]  = '{BASE,              1'b1, 64'hDEAD,             8'h00, 1'b0, 64'h0};
        tbl[10] = '{BASE,              1'b0, 64'h0,                8'h00, 1'b0, 64'h112233AABB667788};
`ifdef DATA_SRAM_MISALIGN_CHK_EN
        tbl[11] = '{BASE + 64'd6,      1'b1, 64'h44332211,         8'h0F, 1'b1, 64'h0};
        tbl[12] = '{BASE,              1'b0, 64'h0,                8'h00, 1'b0, 64'h112233AABB667788};
`else
        tbl[11] = '{BASE + 64'd6,      1'b1, 64'h44332211,         8'h0F, 1'b0, 64'h0};
        tbl[12] = '{BASE,              1'b0, 64'h0,                8'h00, 1'b0, 64'h221133AABB667788};
`endif
        tbl[13] = '{64'h8000_7FF8,     1'b1, 64'h0102030405060708, 8'hFF, 1'b0, 64'h0};
        tbl[14] = '{64'h8000_7FFF,     1'b0, 64'h0,                8'h00, 1'b0, 64'h01};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);

        // Directed vectors
        for (int i = 0; i < 15; i++) begin
            do_req(tbl[i].addr, tbl[i].wen, tbl[i].wdata, tbl[i].wmask, rd, er);
            check($sformatf("vec%0d_err", i), 64'(er), 64'(tbl[i].exp_err));
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
        end

        // Hold resp_ready low; a second request must be ignored
        do_req(BASE, 1'b1, 64'h0A0B0C0D0E0F1011, 8'hFF, rd, er);
        req_valid = 1'b1; req_addr = BASE; req_wen = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        held = resp_rdata;
        check("hold_first_rdata", held, 64'h0A0B0C0D0E0F1011);
        req_valid = 1'b1; req_addr = BASE; req_wen = 1'b1;
        req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_wmask = 8'hFF;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", 64'(resp_valid), 64'd1);
            check("stall_rdata", resp_rdata, held);
            check("stall_req_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check("release_valid", 64'(resp_valid), 64'd0);
        check("release_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        do_req(BASE, 1'b0, 64'h0, 8'h00, rd, er);
        check("ignored_store_rdata", rd, 64'h0A0B0C0D0E0F1011);

        // Reset while a response is pending clears outputs at once
        req_valid = 1'b1; req_addr = BASE; req_wen = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_valid", 64'(resp_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(resp_valid), 64'd0);
        check("async_rst_rdata", resp_rdata, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-BUSY aborts the store
        do_req(BASE + 64'h10, 1'b1, 64'h0123456789ABCDEF, 8'hFF, rd, er);
        req_valid = 1'b1; req_addr = BASE + 64'h10; req_wen = 1'b1;
        req_wdata = 64'hFFFF_FFFF_FFFF_FFFF; req_wmask = 8'hFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_resp_valid", 64'(resp_valid), 64'd0);
        check("abort_resp_err", 64'(resp_err), 64'd0);
        check("abort_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_req(BASE + 64'h10, 1'b0, 64'h0, 8'h00, rd, er);
        check("abort_prior_contents", rd, 64'h0123456789ABCDEF);

        // Randomized traffic against the reference model
        for (int k = 0; k < 8; k++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            model_op(BASE + 64'(8*k), 1'b1, d, 8'hFF, er, rd);
            do_req(BASE + 64'(8*k), 1'b1, d, 8'hFF, rd, er);
            check("init_err", 64'(er), 64'd0);
        end
        for (int t = 0; t < 60; t++) begin
            logic [63:0] a;
            logic        w;
            logic [63:0] d;
            logic [7:0]  m;
            logic        e_err;
            logic [63:0] e_rd;
            int          kind;
            kind = $urandom_range(0, 9);
            d = {$urandom, $urandom};
            m = 8'($urandom);
            if (kind <= 7) begin
                a = BASE + 64'(8 * $urandom_range(0, 7)) + 64'($urandom_range(0, 7));
                w = (kind <= 3);
            end else if (kind == 8) begin
                a = BASE - 64'($urandom_range(1, 4096));
                w = 1'($urandom);
            end else begin
                a = BASE + SPAN + 64'($urandom_range(0, 70000));
                w = 1'($urandom);
            end
            model_op(a, w, d, m, e_err, e_rd);
            exp_q.push_back({e_err, e_rd});
            do_req(a, w, d, m, rd, er);
            exp = exp_q.pop_front();
            check("rand_err", 64'(er), 64'(exp[64]));
            check("rand_rdata", rd, exp[63:0]);
        end

        // Final read-back of the modelled words
        for (int k = 0; k < 8; k++) begin
            do_req(BASE + 64'(8*k), 1'b0, 64'h0, 8'h00, rd, er);
            check("final_word", rd, ref_mem[k]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
